// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between imem read, dmem read and dmem write.
// Define ARB_RR_EN for round-robin arbitration instead of fixed priority.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          im_ready,
    output logic          im_valid,
    input  logic [AW-1:0] im_addr,
    output logic          im_rresp,
    output logic [31:0]   im_rdata,
    input  logic          dr_ready,
    output logic          dr_valid,
    input  logic [AW-1:0] dr_addr,
    output logic          dr_rresp,
    output logic [31:0]   dr_rdata,
    input  logic          dw_ready,
    output logic          dw_valid,
    input  logic [AW-1:0] dw_addr,
    input  logic [31:0]   dw_wdata,
    input  logic [3:0]    dw_wstrb,
    output logic          mem_ready,
    input  logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_rresp,
    input  logic [31:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] O_NONE = 2'd0;
    localparam logic [1:0] O_IM   = 2'd1;
    localparam logic [1:0] O_DR   = 2'd2;
    localparam logic [1:0] O_DW   = 2'd3;

    logic [1:0] r_state;
    logic [1:0] r_owner;
    logic [1:0] w_state_nxt;
    logic [1:0] w_owner_nxt;
    logic [1:0] w_win;
    logic       w_wacc;
    logic       w_arb;
    logic       w_dw_req;

`ifdef ARB_RR_EN
    logic [1:0] r_ptr;
`else
    localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
    logic [7:0] r_starve;
`endif

    always_ff @(posedge clk) begin
        if (resetb) begin
            r_state  <= S_IDLE;
            r_owner  <= O_NONE;
`ifdef ARB_RR_EN
            r_ptr    <= O_IM;
`else
            r_starve <= 8'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
`ifdef ARB_RR_EN
            if (w_win != O_NONE)
                r_ptr <= w_win;
`else
            if (w_win == O_IM || !im_ready)
                r_starve <= 8'd0;
            else if (!(r_state == S_BUSY && r_owner == O_IM) && r_starve != LIM)
                r_starve <= r_starve + 8'd1;
`endif
        end
    end

    // The write being accepted this cycle still shows its request; mask it
    // so the re-arbitration sees only fresh requesters.
    always_comb begin
        w_wacc   = (r_state == S_BUSY) && mem_valid && (r_owner == O_DW);
        w_arb    = (r_state == S_IDLE) || (r_state == S_RESP) || w_wacc;
        w_dw_req = dw_ready && !w_wacc;
        w_win    = O_NONE;
`ifdef ARB_RR_EN
        case (r_ptr)
            O_DW: begin
                if (dr_ready)      w_win = O_DR;
                else if (im_ready) w_win = O_IM;
                else if (w_dw_req) w_win = O_DW;
            end
            O_DR: begin
                if (im_ready)      w_win = O_IM;
                else if (w_dw_req) w_win = O_DW;
                else if (dr_ready) w_win = O_DR;
            end
            default: begin
                if (w_dw_req)      w_win = O_DW;
                else if (dr_ready) w_win = O_DR;
                else if (im_ready) w_win = O_IM;
            end
        endcase
`else
        if (im_ready && r_starve == LIM) w_win = O_IM;
        else if (w_dw_req)               w_win = O_DW;
        else if (dr_ready)               w_win = O_DR;
        else if (im_ready)               w_win = O_IM;
`endif
        if (!w_arb)
            w_win = O_NONE;

        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_state_nxt = (w_win != O_NONE) ? S_BUSY : S_IDLE;
                w_owner_nxt = w_win;
            end
            S_BUSY: begin
                if (mem_valid) begin
                    if (r_owner == O_DW) begin
                        w_state_nxt = (w_win != O_NONE) ? S_BUSY : S_IDLE;
                        w_owner_nxt = w_win;
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_owner_nxt = O_NONE;
            end
        endcase
    end

    always_comb begin
        mem_ready = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        im_valid  = 1'b0;
        dr_valid  = 1'b0;
        dw_valid  = 1'b0;
        im_rresp  = 1'b0;
        im_rdata  = 32'd0;
        dr_rresp  = 1'b0;
        dr_rdata  = 32'd0;
        if (r_state == S_BUSY) begin
            mem_ready = 1'b1;
            case (r_owner)
                O_IM: begin
                    mem_addr = im_addr;
                    im_valid = mem_valid;
                end
                O_DR: begin
                    mem_addr = dr_addr;
                    dr_valid = mem_valid;
                end
                O_DW: begin
                    mem_we    = 1'b1;
                    mem_addr  = dw_addr;
                    mem_wdata = dw_wdata;
                    mem_wstrb = dw_wstrb;
                    dw_valid  = mem_valid;
                end
                default: ;
            endcase
        end
        if (r_state == S_RESP) begin
            case (r_owner)
                O_IM: begin
                    im_rresp = mem_rresp;
                    im_rdata = mem_rdata;
                end
                O_DR: begin
                    dr_rresp = mem_rresp;
                    dr_rdata = mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand sequences,
// and per-channel read-data scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetb;
    logic        im_ready, im_valid, im_rresp;
    logic [31:0] im_addr, im_rdata;
    logic        dr_ready, dr_valid, dr_rresp;
    logic [31:0] dr_addr, dr_rdata;
    logic        dw_ready, dw_valid;
    logic [31:0] dw_addr, dw_wdata;
    logic [3:0]  dw_wstrb;
    logic        mem_ready, mem_valid, mem_we, mem_rresp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        m_rresp = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        x_rresp = 1'b0;
    logic        loaded  = 1'b0;
    logic [31:0] tmem [0:255];

    int total = 0;
    int bad   = 0;
    logic [31:0] q_im[$];
    logic [31:0] q_dr[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(8), .AW(32)) dut (
        .clk(clk), .resetb(resetb),
        .im_ready(im_ready), .im_valid(im_valid), .im_addr(im_addr),
        .im_rresp(im_rresp), .im_rdata(im_rdata),
        .dr_ready(dr_ready), .dr_valid(dr_valid), .dr_addr(dr_addr),
        .dr_rresp(dr_rresp), .dr_rdata(dr_rdata),
        .dw_ready(dw_ready), .dw_valid(dw_valid), .dw_addr(dw_addr),
        .dw_wdata(dw_wdata), .dw_wstrb(dw_wstrb),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rresp(mem_rresp), .mem_rdata(mem_rdata)
    );

    assign mem_rresp = m_rresp | x_rresp;
    assign mem_rdata = x_rresp ? 32'hBAD0BAD0 : m_rdata;

    // Memory model: read data one cycle after an accepted read.
    always @(posedge clk) begin
        m_rresp <= 1'b0;
        if (!loaded) begin
            for (int i = 0; i < 256; i++)
                tmem[i] <= (i == 64)  ? 32'hDEADBEEF :
                           (i == 128) ? 32'hCAFEF00D :
                           (i == 193) ? 32'h11223344 : 32'd0;
            loaded <= 1'b1;
        end else if (mem_ready && mem_valid) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b])
                        tmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                m_rresp <= 1'b1;
                m_rdata <= tmem[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (im_rresp) begin
            if (q_im.size() == 0) begin
                total++;
                bad++;
                $display("FAIL im_rresp_unexpected: got %0h want none", im_rdata);
            end else begin
                chk("im_rdata", im_rdata, q_im.pop_front());
                chk("dr_rdata_quiet", dr_rdata, 0);
            end
        end
        if (dr_rresp) begin
            if (q_dr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dr_rresp_unexpected: got %0h want none", dr_rdata);
            end else begin
                chk("dr_rdata", dr_rdata, q_dr.pop_front());
                chk("im_rdata_quiet", im_rdata, 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetb    = 1'b1;
        im_ready  = 1'b0;
        dr_ready  = 1'b0;
        dw_ready  = 1'b0;
        mem_valid = 1'b0;
        x_rresp   = 1'b0;
        repeat (2) cyc();
        resetb = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_mem"}, {mem_ready, mem_we, mem_wstrb, mem_addr, mem_wdata}, 0);
        chk({nm, "_ch"}, {im_valid, dr_valid, dw_valid, im_rresp, dr_rresp}, 0);
        chk({nm, "_rdata"}, {im_rdata, dr_rdata}, 0);
    endtask

    typedef struct {
        logic        im;
        logic        dr;
        logic        dw;
        logic [2:0]  vld;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[8];
    int   exp_ord[9];
    int   ord[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int c_im;

        // {im, dr, dw, valid{dw,dr,im}, addr, we, strb, read data}
        tv[0] = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h000, 1'b0, 4'h0, 32'h0};
        tv[1] = '{1'b1, 1'b0, 1'b0, 3'b001, 32'h100, 1'b0, 4'h0, 32'hDEADBEEF};
        tv[2] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h200, 1'b0, 4'h0, 32'hCAFEF00D};
        tv[3] = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 1'b0, 4'h0, 32'hCAFEF00D};
        tv[4] = '{1'b0, 1'b0, 1'b1, 3'b100, 32'h300, 1'b1, 4'h6, 32'h0};
        tv[5] = '{1'b1, 1'b0, 1'b1, 3'b100, 32'h300, 1'b1, 4'h6, 32'h0};
        tv[6] = '{1'b0, 1'b1, 1'b1, 3'b100, 32'h300, 1'b1, 4'h6, 32'h0};
        tv[7] = '{1'b1, 1'b1, 1'b1, 3'b100, 32'h300, 1'b1, 4'h6, 32'h0};
`ifdef ARB_RR_EN
        exp_ord = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
`else
        exp_ord = '{3, 2, 3, 2, 3, 2, 1, 3, 2};
`endif
        im_addr  = 32'h100;
        dr_addr  = 32'h200;
        dw_addr  = 32'h300;
        dw_wdata = 32'hA5A55A5A;
        dw_wstrb = 4'b0110;

        do_reset();
        @(negedge clk);
        chk_zero("reset");

        for (int k = 0; k < 8; k++) begin
            do_reset();
            im_ready  = tv[k].im;
            dr_ready  = tv[k].dr;
            dw_ready  = tv[k].dw;
            mem_valid = 1'b0;
            cyc();
            @(negedge clk);
            chk($sformatf("v%0d_ready", k), mem_ready, |tv[k].vld);
            chk($sformatf("v%0d_we", k), mem_we, tv[k].we);
            chk($sformatf("v%0d_addr", k), mem_addr, tv[k].addr);
            chk($sformatf("v%0d_strb", k), mem_wstrb, tv[k].strb);
            chk($sformatf("v%0d_wdata", k), mem_wdata,
                tv[k].we ? 32'hA5A55A5A : 32'h0);
            chk($sformatf("v%0d_stall_vld", k),
                {dw_valid, dr_valid, im_valid}, 0);
            cyc();
            mem_valid = 1'b1;
            if (tv[k].vld[0]) q_im.push_back(tv[k].rd);
            if (tv[k].vld[1]) q_dr.push_back(tv[k].rd);
            @(negedge clk);
            chk($sformatf("v%0d_vld", k), {dw_valid, dr_valid, im_valid}, tv[k].vld);
            cyc();
            im_ready  = 1'b0;
            dr_ready  = 1'b0;
            dw_ready  = 1'b0;
            mem_valid = 1'b0;
            @(negedge clk);
        end

        // Single imem read, memory always accepting.
        do_reset();
        im_ready  = 1'b1;
        mem_valid = 1'b1;
        q_im.push_back(32'hDEADBEEF);
        cyc();
        @(negedge clk);
        chk("a_ready", {mem_ready, im_valid, mem_we}, 3'b110);
        chk("a_addr", mem_addr, 32'h100);
        cyc();
        im_ready = 1'b0;
        @(negedge clk);
        chk("a_rresp", {im_rresp, dr_rresp}, 2'b10);
        chk("a_rdata", im_rdata, 32'hDEADBEEF);

        // Write then read of the same word; read sees the merged bytes.
        do_reset();
        dw_addr   = 32'h304;
        dr_addr   = 32'h304;
        dw_ready  = 1'b1;
        dr_ready  = 1'b1;
        mem_valid = 1'b1;
        q_dr.push_back(32'h11A55A44);
        cyc();
        @(negedge clk);
        chk("b_dw", {mem_we, mem_wstrb, dw_valid, dr_valid}, 7'b1_0110_10);
        chk("b_dw_addr", {mem_addr, mem_wdata}, {32'h304, 32'hA5A55A5A});
        cyc();
        dw_ready = 1'b0;
        @(negedge clk);
        chk("b_dr", {mem_ready, mem_we, mem_wstrb, dw_valid, dr_valid},
            8'b1_0_0000_01);
        cyc();
        dr_ready = 1'b0;
        @(negedge clk);
        chk("b_rresp", dr_rresp, 1'b1);
        dr_addr = 32'h200;
        dw_addr = 32'h300;

        // Stall in BUSY: request held stable, accept routed to owner only.
        do_reset();
        dr_ready = 1'b1;
        im_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("d_stall%0d", c),
                {mem_ready, mem_addr, dw_valid, dr_valid, im_valid},
                {1'b1, 32'h200, 3'b000});
        end
        cyc();
        mem_valid = 1'b1;
        q_dr.push_back(32'hCAFEF00D);
        @(negedge clk);
        chk("d_accept", {dw_valid, dr_valid, im_valid}, 3'b010);
        cyc();
        dr_ready = 1'b0;
        cyc();
        q_im.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("d_im_next", {dw_valid, dr_valid, im_valid, mem_addr},
            {3'b001, 32'h100});
        cyc();
        im_ready = 1'b0;
        cyc();

        // All three requesting continuously: grant order and starvation bound.
        do_reset();
        im_ready  = 1'b1;
        dr_ready  = 1'b1;
        dw_ready  = 1'b1;
        mem_valid = 1'b1;
        n    = 0;
        c_im = -1;
        for (int c = 0; c < 60 && n < 9; c++) begin
            @(negedge clk);
            if (dw_valid) begin
                ord[n] = 3;
                n++;
            end else if (dr_valid) begin
                ord[n] = 2;
                n++;
                q_dr.push_back(32'hCAFEF00D);
            end else if (im_valid) begin
                if (c_im < 0) c_im = c;
                ord[n] = 1;
                n++;
                q_im.push_back(32'hDEADBEEF);
            end
        end
        chk("s_count", n, 9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("s_order%0d", i), ord[i], exp_ord[i]);
        chk("s_im_wait", (c_im >= 0 && c_im <= 10), 1'b1);
        cyc();
        im_ready  = 1'b0;
        dr_ready  = 1'b0;
        dw_ready  = 1'b0;
        mem_valid = 1'b0;
        repeat (2) cyc();

        // Reset while a read response is outstanding.
        do_reset();
        im_ready  = 1'b1;
        mem_valid = 1'b1;
        q_im.push_back(32'hDEADBEEF);
        cyc();
        cyc();
        im_ready = 1'b0;
        resetb   = 1'b1;
        cyc();
        x_rresp = 1'b1;
        @(negedge clk);
        chk_zero("e_reset");
        cyc();
        x_rresp = 1'b0;
        resetb  = 1'b0;
        repeat (2) cyc();

        chk("q_im_empty", q_im.size(), 0);
        chk("q_dr_empty", q_dr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
